// File: rtl/cond_gen_ready_valid_stage.sv
// Ready/valid register stage; MODE selects pipe register, skid buffer or 2-entry FIFO.
// Latency 1 cycle from push to out_valid when empty; optional pop counter via COND_GEN_STAGE_COUNT_EN.
// Backpressure: MODE0 in_ready is combinational from out_ready, MODE1 and FIFO drive in_ready from flops only.
module cond_gen_ready_valid_stage #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef COND_GEN_STAGE_COUNT_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    logic push;
    logic pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Module-scope temp: sticky flag for an input stall lasting more than 255 cycles.
    logic       temp;
    logic       temp_d;
    logic [7:0] stall_cnt_q;
    logic [7:0] stall_cnt_d;
    logic       stall;

    assign stall = in_valid & ~in_ready;

    always_comb begin
        stall_cnt_d = 8'd0;
        temp_d      = temp;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
            if (stall_cnt_q == 8'hFF) begin
                temp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 8'd0;
            temp        <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            temp        <= temp_d;
        end
    end

    if (MODE == 0) begin : g_pipe
        logic [WIDTH-1:0] temp;
        logic             out_valid_q;

        assign in_ready  = ~out_valid_q | out_ready;
        assign out_valid = out_valid_q;
        assign out_data  = temp;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                temp        <= '0;
                out_valid_q <= 1'b0;
            end else if (push) begin
                temp        <= in_data;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end else if (MODE == 1) begin : g_skid
        // temp = {skid_valid, skid_data}
        logic [WIDTH:0]   temp;
        logic [WIDTH-1:0] data_q;
        logic             out_valid_q;

        assign in_ready  = ~temp[WIDTH];
        assign out_valid = out_valid_q;
        assign out_data  = data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                temp        <= '0;
                data_q      <= '0;
                out_valid_q <= 1'b0;
            end else if (pop) begin
                if (temp[WIDTH]) begin
                    data_q       <= temp[WIDTH-1:0];
                    temp[WIDTH]  <= 1'b0;
                end else if (push) begin
                    data_q <= in_data;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (push) begin
                if (out_valid_q) begin
                    temp <= {1'b1, in_data};
                end else begin
                    data_q      <= in_data;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end else begin : g_fifo
        logic [WIDTH-1:0] temp [2];
        logic             wr_ptr;
        logic             rd_ptr;
        logic [1:0]       count;

        assign in_ready  = (count != 2'd2);
        assign out_valid = (count != 2'd0);
        assign out_data  = temp[rd_ptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                temp[0] <= '0;
                temp[1] <= '0;
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
                count   <= 2'd0;
            end else begin
                if (push) begin
                    temp[wr_ptr] <= in_data;
                    wr_ptr       <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef COND_GEN_STAGE_COUNT_EN
    logic [CNT_W-1:0] xfer_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
        end else if (pop) begin
            xfer_count_q <= xfer_count_q + 1'b1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_cond_gen_ready_valid_stage.sv
// Directed table-driven bench covering all three storage modes side by side.
module tb_cond_gen_ready_valid_stage;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic [7:0] id   [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       ov   [3];
    logic [7:0] od   [3];
`ifdef COND_GEN_STAGE_COUNT_EN
    logic [3:0] xc   [3];
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cond_gen_ready_valid_stage #(.WIDTH(8), .MODE(0), .CNT_W(4)) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0])
`ifdef COND_GEN_STAGE_COUNT_EN
        , .xfer_count(xc[0])
`endif
    );

    cond_gen_ready_valid_stage #(.WIDTH(8), .MODE(1), .CNT_W(4)) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1])
`ifdef COND_GEN_STAGE_COUNT_EN
        , .xfer_count(xc[1])
`endif
    );

    cond_gen_ready_valid_stage #(.WIDTH(8), .MODE(2), .CNT_W(4)) u_m2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2])
`ifdef COND_GEN_STAGE_COUNT_EN
        , .xfer_count(xc[2])
`endif
    );

    typedef struct {
        int         mode;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            id[k]   = 8'h00;
            ordy[k] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mode, in_valid, in_data, out_ready | expected in_ready, out_valid, out_data (before the edge)
        vecs[0]  = '{0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[2]  = '{0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[3]  = '{0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[4]  = '{0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[5]  = '{0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[6]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[7]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[8]  = '{0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22};
        vecs[9]  = '{1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[11] = '{1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[12] = '{1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01};
        vecs[13] = '{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02};
        vecs[14] = '{1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h02};
        vecs[15] = '{1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h04};
        vecs[16] = '{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05};
        vecs[17] = '{1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05};
        vecs[18] = '{2, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{2, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 8'h10};
        vecs[20] = '{2, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h10};
        vecs[21] = '{2, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 8'h10};
        vecs[22] = '{2, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 8'h20};
        vecs[23] = '{2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20};
        vecs[24] = '{2, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h30};
        vecs[25] = '{2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40};
        vecs[26] = '{2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h30};

        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ov_m%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("reset_od_m%0d", k), 32'(od[k]), 32'd0);
            chk($sformatf("reset_ir_m%0d", k), 32'(ir[k]), 32'd1);
`ifdef COND_GEN_STAGE_COUNT_EN
            chk($sformatf("reset_xc_m%0d", k), 32'(xc[k]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        step();

        for (int v = 0; v < NV; v++) begin
            idle_all();
            iv[vecs[v].mode]   = vecs[v].iv;
            id[vecs[v].mode]   = vecs[v].d;
            ordy[vecs[v].mode] = vecs[v].ordy;
            #2;
            chk($sformatf("vec%0d_in_ready", v),  32'(ir[vecs[v].mode]), 32'(vecs[v].e_ir));
            chk($sformatf("vec%0d_out_valid", v), 32'(ov[vecs[v].mode]), 32'(vecs[v].e_ov));
            chk($sformatf("vec%0d_out_data", v),  32'(od[vecs[v].mode]), 32'(vecs[v].e_od));
            step();
        end

        // Load every stage with held words, then reset asynchronously between edges.
        idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1;
            id[k] = 8'hC1;
        end
        step();
        for (int k = 0; k < 3; k++) id[k] = 8'hC2;
        step();
        idle_all();
        #1;
        chk("preload_m1_full_ir", 32'(ir[1]), 32'd0);
        chk("preload_m2_full_ir", 32'(ir[2]), 32'd0);
        chk("preload_m0_od", 32'(od[0]), 32'hC1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rst_ov_m%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("async_rst_od_m%0d", k), 32'(od[k]), 32'd0);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_ir_m%0d", k), 32'(ir[k]), 32'd1);
            chk($sformatf("post_rst_ov_m%0d", k), 32'(ov[k]), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1;
            id[k] = 8'h77;
        end
        step();
        idle_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("first_push_ov_m%0d", k), 32'(ov[k]), 32'd1);
            chk($sformatf("first_push_od_m%0d", k), 32'(od[k]), 32'h77);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold_od_m%0d", k), 32'(od[k]), 32'h77);
            ordy[k] = 1'b1;
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drained_ov_m%0d", k), 32'(ov[k]), 32'd0);
        end

`ifdef COND_GEN_STAGE_COUNT_EN
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        id[0]   = 8'h5A;
        // First edge only fills the stage; the next 17 each pop one word.
        repeat (18) step();
        idle_all();
        #1;
        chk("xfer_count_wrap", 32'(xc[0]), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
